// File: rtl/fft32_pkg.sv
// Shared constants, twiddle tables, complex sample type and index helper for the
// 32-point radix-2 DIT FFT front end.
package fft32_pkg;

    localparam int N       = 32;
    localparam int IN_W    = 2;
    localparam int DW      = 14;
    localparam int TW_W    = 8;
    localparam int TW_FRAC = 6;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // W^k = TW_COS[k] - j*TW_SIN[k], scaled by 2^TW_FRAC
    localparam logic signed [TW_W-1:0] TW_COS [16] = '{
        8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
        8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63
    };

    localparam logic signed [TW_W-1:0] TW_SIN [16] = '{
        8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63,
        8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12
    };

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

endpackage

// File: rtl/fft32_bfly.sv
// Combinational radix-2 DIT butterfly: a' = a + W*b, b' = a - W*b.
// Define FFT32_ROUND_EN to round half up on scaled products instead of truncating.
module fft32_bfly
    import fft32_pkg::*;
(
    input  cplx_t      a,
    input  cplx_t      b,
    input  logic [3:0] tw,
    output cplx_t      ap,
    output cplx_t      bp
);

    localparam int PW = DW + TW_W;
    localparam int AW = PW + 1;

`ifdef FFT32_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'(1 << (TW_FRAC - 1));
`else
    localparam logic signed [AW-1:0] RND = '0;
`endif

    logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [AW-1:0] acc_re, acc_im;
    cplx_t                wb;

    always_comb begin
        p_rc   = '0;
        p_is   = '0;
        p_ic   = '0;
        p_rs   = '0;
        acc_re = '0;
        acc_im = '0;
        wb     = b;
        case (tw)
            4'd0: wb = b;
            // multiply by -j is a swap and negate
            4'd8: begin
                wb.re = b.im;
                wb.im = -b.re;
            end
            default: begin
                p_rc   = PW'($signed(b.re)) * PW'(TW_COS[tw]);
                p_is   = PW'($signed(b.im)) * PW'(TW_SIN[tw]);
                p_ic   = PW'($signed(b.im)) * PW'(TW_COS[tw]);
                p_rs   = PW'($signed(b.re)) * PW'(TW_SIN[tw]);
                acc_re = AW'(p_rc) + AW'(p_is) + RND;
                acc_im = AW'(p_ic) - AW'(p_rs) + RND;
                wb.re  = DW'(acc_re >>> TW_FRAC);
                wb.im  = DW'(acc_im >>> TW_FRAC);
            end
        endcase
        ap.re = a.re + wb.re;
        ap.im = a.im + wb.im;
        bp.re = a.re - wb.re;
        bp.im = a.im - wb.im;
    end

endmodule

// File: rtl/fft_32pt_stage1.sv
// Fully parallel 5-stage pipelined 32-point radix-2 DIT FFT, one vector per clock.
// Rounding of twiddle products is selected by FFT32_ROUND_EN (see fft32_bfly).
module fft_32pt_stage1
    import fft32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IN_W-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
                                 r8,  r9,  r10, r11, r12, r13, r14, r15,
                                 r16, r17, r18, r19, r20, r21, r22, r23,
                                 r24, r25, r26, r27, r28, r29, r30, r31,
    input  logic signed [IN_W-1:0] i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,
                                 i8,  i9,  i10, i11, i12, i13, i14, i15,
                                 i16, i17, i18, i19, i20, i21, i22, i23,
                                 i24, i25, i26, i27, i28, i29, i30, i31,
    output logic signed [DW-1:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
                                 R8,  R9,  R10, R11, R12, R13, R14, R15,
                                 R16, R17, R18, R19, R20, R21, R22, R23,
                                 R24, R25, R26, R27, R28, R29, R30, R31,
    output logic signed [DW-1:0] I0,  I1,  I2,  I3,  I4,  I5,  I6,  I7,
                                 I8,  I9,  I10, I11, I12, I13, I14, I15,
                                 I16, I17, I18, I19, I20, I21, I22, I23,
                                 I24, I25, I26, I27, I28, I29, I30, I31
);

    localparam int STAGES = 5;

    logic [N*IN_W-1:0] in_re_flat, in_im_flat;
    logic [N*DW-1:0]   out_re_flat, out_im_flat;

    // stg[0] is the bit-reversed input register, stg[s] the output of stage s
    cplx_t stg [0:STAGES][0:N-1];
    cplx_t bfo [1:STAGES][0:N-1];

    assign in_re_flat = {r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
                         r8,  r9,  r10, r11, r12, r13, r14, r15,
                         r16, r17, r18, r19, r20, r21, r22, r23,
                         r24, r25, r26, r27, r28, r29, r30, r31};
    assign in_im_flat = {i0,  i1,  i2,  i3,  i4,  i5,  i6,  i7,
                         i8,  i9,  i10, i11, i12, i13, i14, i15,
                         i16, i17, i18, i19, i20, i21, i22, i23,
                         i24, i25, i26, i27, i28, i29, i30, i31};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s <= STAGES; s++) begin
                for (int unsigned n = 0; n < N; n++) begin
                    stg[s][n] <= '0;
                end
            end
        end else begin
            for (int unsigned n = 0; n < N; n++) begin
                stg[0][n].re <= DW'($signed(in_re_flat[(N - 1 - int'(bitrev5(5'(n)))) * IN_W +: IN_W]));
                stg[0][n].im <= DW'($signed(in_im_flat[(N - 1 - int'(bitrev5(5'(n)))) * IN_W +: IN_W]));
            end
            for (int unsigned s = 1; s <= STAGES; s++) begin
                for (int unsigned n = 0; n < N; n++) begin
                    stg[s][n] <= bfo[s][n];
                end
            end
        end
    end

    // Stage s pairs p with p+H inside groups of 2H; twiddle index steps by 16/H
    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int H = 1 << (s - 1);
        for (genvar j = 0; j < N / 2; j++) begin : g_bf
            localparam int OFF = j % H;
            localparam int P   = (j / H) * 2 * H + OFF;
            localparam logic [3:0] TW = 4'(OFF * (16 / H));
            fft32_bfly u_bfly (
                .a  (stg[s-1][P]),
                .b  (stg[s-1][P+H]),
                .tw (TW),
                .ap (bfo[s][P]),
                .bp (bfo[s][P+H])
            );
        end
    end

    always_comb begin
        out_re_flat = '0;
        out_im_flat = '0;
        for (int unsigned k = 0; k < N; k++) begin
            out_re_flat[(N - 1 - k) * DW +: DW] = stg[STAGES][k].re;
            out_im_flat[(N - 1 - k) * DW +: DW] = stg[STAGES][k].im;
        end
    end

    assign {R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
            R8,  R9,  R10, R11, R12, R13, R14, R15,
            R16, R17, R18, R19, R20, R21, R22, R23,
            R24, R25, R26, R27, R28, R29, R30, R31} = out_re_flat;
    assign {I0,  I1,  I2,  I3,  I4,  I5,  I6,  I7,
            I8,  I9,  I10, I11, I12, I13, I14, I15,
            I16, I17, I18, I19, I20, I21, I22, I23,
            I24, I25, I26, I27, I28, I29, I30, I31} = out_im_flat;

endmodule

// File: tb/tb_fft_32pt_stage1.sv
// Self-checking bench for fft_32pt_stage1: directed exact cases plus a random stream
// compared against a fixed-point FFT model built from cos/sin.
module tb_fft_32pt_stage1;

    logic clk = 1'b0;
    logic rst;
    logic signed [1:0]  xr [32];
    logic signed [1:0]  xi [32];
    logic signed [13:0] yr [32];
    logic signed [13:0] yi [32];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FFT32_ROUND_EN
    localparam int RND = 32;
`else
    localparam int RND = 0;
`endif

    int tw_c [16];
    int tw_s [16];
    int m_in_r [32], m_in_i [32], m_out_r [32], m_out_i [32];
    int exp_r [0:39][0:31];
    int exp_i [0:39][0:31];

    always #5 clk = ~clk;

    fft_32pt_stage1 dut (
        .clk(clk), .rst(rst),
        .r0(xr[0]),   .r1(xr[1]),   .r2(xr[2]),   .r3(xr[3]),   .r4(xr[4]),   .r5(xr[5]),   .r6(xr[6]),   .r7(xr[7]),
        .r8(xr[8]),   .r9(xr[9]),   .r10(xr[10]), .r11(xr[11]), .r12(xr[12]), .r13(xr[13]), .r14(xr[14]), .r15(xr[15]),
        .r16(xr[16]), .r17(xr[17]), .r18(xr[18]), .r19(xr[19]), .r20(xr[20]), .r21(xr[21]), .r22(xr[22]), .r23(xr[23]),
        .r24(xr[24]), .r25(xr[25]), .r26(xr[26]), .r27(xr[27]), .r28(xr[28]), .r29(xr[29]), .r30(xr[30]), .r31(xr[31]),
        .i0(xi[0]),   .i1(xi[1]),   .i2(xi[2]),   .i3(xi[3]),   .i4(xi[4]),   .i5(xi[5]),   .i6(xi[6]),   .i7(xi[7]),
        .i8(xi[8]),   .i9(xi[9]),   .i10(xi[10]), .i11(xi[11]), .i12(xi[12]), .i13(xi[13]), .i14(xi[14]), .i15(xi[15]),
        .i16(xi[16]), .i17(xi[17]), .i18(xi[18]), .i19(xi[19]), .i20(xi[20]), .i21(xi[21]), .i22(xi[22]), .i23(xi[23]),
        .i24(xi[24]), .i25(xi[25]), .i26(xi[26]), .i27(xi[27]), .i28(xi[28]), .i29(xi[29]), .i30(xi[30]), .i31(xi[31]),
        .R0(yr[0]),   .R1(yr[1]),   .R2(yr[2]),   .R3(yr[3]),   .R4(yr[4]),   .R5(yr[5]),   .R6(yr[6]),   .R7(yr[7]),
        .R8(yr[8]),   .R9(yr[9]),   .R10(yr[10]), .R11(yr[11]), .R12(yr[12]), .R13(yr[13]), .R14(yr[14]), .R15(yr[15]),
        .R16(yr[16]), .R17(yr[17]), .R18(yr[18]), .R19(yr[19]), .R20(yr[20]), .R21(yr[21]), .R22(yr[22]), .R23(yr[23]),
        .R24(yr[24]), .R25(yr[25]), .R26(yr[26]), .R27(yr[27]), .R28(yr[28]), .R29(yr[29]), .R30(yr[30]), .R31(yr[31]),
        .I0(yi[0]),   .I1(yi[1]),   .I2(yi[2]),   .I3(yi[3]),   .I4(yi[4]),   .I5(yi[5]),   .I6(yi[6]),   .I7(yi[7]),
        .I8(yi[8]),   .I9(yi[9]),   .I10(yi[10]), .I11(yi[11]), .I12(yi[12]), .I13(yi[13]), .I14(yi[14]), .I15(yi[15]),
        .I16(yi[16]), .I17(yi[17]), .I18(yi[18]), .I19(yi[19]), .I20(yi[20]), .I21(yi[21]), .I22(yi[22]), .I23(yi[23]),
        .I24(yi[24]), .I25(yi[25]), .I26(yi[26]), .I27(yi[27]), .I28(yi[28]), .I29(yi[29]), .I30(yi[30]), .I31(yi[31])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        for (int n = 0; n < 32; n++) begin
            m_in_r[n] = 0;
            m_in_i[n] = 0;
        end
    endtask

    task automatic drive_in();
        for (int n = 0; n < 32; n++) begin
            xr[n] = 2'(m_in_r[n]);
            xi[n] = 2'(m_in_i[n]);
        end
    endtask

    task automatic build_twiddles();
        real pi;
        pi = 3.14159265358979;
        for (int k = 0; k < 16; k++) begin
            tw_c[k] =  $rtoi($floor(64.0 * $cos(2.0 * pi * k / 32.0) + 0.5));
            tw_s[k] = -$rtoi($floor(64.0 * $sin(2.0 * pi * k / 32.0) + 0.5));
        end
    endtask

    // Textbook iterative radix-2 DIT FFT in integers, W = (tw_c + j*tw_s)/64
    task automatic model_fft();
        int ar [32], ai [32];
        int rev, k, wr, wi, tr, ti, ur, ui;
        for (int n = 0; n < 32; n++) begin
            rev = 0;
            for (int b = 0; b < 5; b++) if (((n >> b) & 1) != 0) rev = rev | (1 << (4 - b));
            ar[n] = m_in_r[rev];
            ai[n] = m_in_i[rev];
        end
        for (int h = 1; h < 32; h = h * 2) begin
            for (int p = 0; p < 32; p++) begin
                if ((p % (2 * h)) < h) begin
                    k  = (p % h) * (16 / h);
                    wr = tw_c[k];
                    wi = tw_s[k];
                    tr = (ar[p+h] * wr - ai[p+h] * wi + RND) >>> 6;
                    ti = (ar[p+h] * wi + ai[p+h] * wr + RND) >>> 6;
                    ur = ar[p];
                    ui = ai[p];
                    ar[p]   = ur + tr;
                    ai[p]   = ui + ti;
                    ar[p+h] = ur - tr;
                    ai[p+h] = ui - ti;
                end
            end
        end
        for (int n = 0; n < 32; n++) begin
            m_out_r[n] = ar[n];
            m_out_i[n] = ai[n];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 32; n++) begin
            xr[n] = 2'($urandom);
            xi[n] = 2'($urandom);
        end
        tick();
        tick();
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (yr[k] !== 14'sd0 || yi[k] !== 14'sd0) begin
                n_fail++;
                $display("FAIL reset bin %0d: got R=%0d I=%0d, want R=0 I=0", k, yr[k], yi[k]);
            end
        end
        rst = 1'b0;
        clear_in();
        drive_in();
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int k = 0; k < 32; k++) begin
                n_checks++;
                if (yr[k] !== 14'sd0 || yi[k] !== 14'sd0) begin
                    n_fail++;
                    $display("FAIL post_reset cyc %0d bin %0d: got R=%0d I=%0d, want R=0 I=0", c, k, yr[k], yi[k]);
                end
            end
        end
    endtask

    // A lone sample at n=0 must give the same value in every bin
    task automatic test_impulse(input string name, input int re0, input int im0);
        clear_in();
        m_in_r[0] = re0;
        m_in_i[0] = im0;
        drive_in();
        repeat (6) tick();
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (yr[k] !== 14'(re0) || yi[k] !== 14'(im0)) begin
                n_fail++;
                $display("FAIL %s bin %0d: got R=%0d I=%0d, want R=%0d I=%0d", name, k, yr[k], yi[k], re0, im0);
            end
        end
    endtask

    task automatic test_dc();
        clear_in();
        for (int n = 0; n < 32; n++) m_in_r[n] = 1;
        drive_in();
        repeat (6) tick();
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (yr[k] !== 14'((k == 0) ? 32 : 0) || yi[k] !== 14'sd0) begin
                n_fail++;
                $display("FAIL dc bin %0d: got R=%0d I=%0d, want R=%0d I=0", k, yr[k], yi[k], (k == 0) ? 32 : 0);
            end
        end
    endtask

    task automatic test_mixed();
        clear_in();
        for (int n = 0; n < 16; n++) m_in_r[n] = 1;
        for (int n = 16; n < 32; n++) m_in_i[n] = 1;
        drive_in();
        model_fft();
        repeat (6) tick();
        n_checks++;
        if (yr[0] !== 14'sd16 || yi[0] !== 14'sd16) begin
            n_fail++;
            $display("FAIL mixed bin 0: got R=%0d I=%0d, want R=16 I=16", yr[0], yi[0]);
        end
        for (int k = 1; k < 32; k++) begin
            n_checks++;
            if ((k % 2) == 0) begin
                if (yr[k] !== 14'sd0 || yi[k] !== 14'sd0) begin
                    n_fail++;
                    $display("FAIL mixed even bin %0d: got R=%0d I=%0d, want R=0 I=0", k, yr[k], yi[k]);
                end
            end else if (yr[k] !== 14'(m_out_r[k]) || yi[k] !== 14'(m_out_i[k])) begin
                n_fail++;
                $display("FAIL mixed odd bin %0d: got R=%0d I=%0d, want R=%0d I=%0d", k, yr[k], yi[k], m_out_r[k], m_out_i[k]);
            end
        end
    endtask

    // New random vector every cycle; bins for the vector sampled at edge t appear after edge t+5
    task automatic test_random_stream();
        localparam int NV = 32;
        for (int t = 0; t < NV + 5; t++) begin
            if (t < NV) begin
                for (int n = 0; n < 32; n++) begin
                    m_in_r[n] = int'($urandom_range(0, 3)) - 2;
                    m_in_i[n] = int'($urandom_range(0, 3)) - 2;
                end
                model_fft();
                for (int k = 0; k < 32; k++) begin
                    exp_r[t][k] = m_out_r[k];
                    exp_i[t][k] = m_out_i[k];
                end
            end else begin
                clear_in();
            end
            drive_in();
            tick();
            if (t >= 5) begin
                for (int k = 0; k < 32; k++) begin
                    n_checks++;
                    if (yr[k] !== 14'(exp_r[t-5][k]) || yi[k] !== 14'(exp_i[t-5][k])) begin
                        n_fail++;
                        $display("FAIL random vec %0d bin %0d: got R=%0d I=%0d, want R=%0d I=%0d",
                                 t - 5, k, yr[k], yi[k], exp_r[t-5][k], exp_i[t-5][k]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_in(); m_in_r[0] = 1; drive_in();
        tick();
        clear_in(); for (int n = 0; n < 32; n++) m_in_r[n] = 1; drive_in();
        tick();
        clear_in(); drive_in();
        repeat (4) tick();
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (yr[k] !== 14'sd1 || yi[k] !== 14'sd0) begin
                n_fail++;
                $display("FAIL b2b impulse bin %0d: got R=%0d I=%0d, want R=1 I=0", k, yr[k], yi[k]);
            end
        end
        tick();
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (yr[k] !== 14'((k == 0) ? 32 : 0) || yi[k] !== 14'sd0) begin
                n_fail++;
                $display("FAIL b2b dc bin %0d: got R=%0d I=%0d, want R=%0d I=0", k, yr[k], yi[k], (k == 0) ? 32 : 0);
            end
        end
        repeat (6) tick();

        // Same pair again, but reset at cycle 3 flushes both in-flight vectors
        clear_in(); m_in_r[0] = 1; drive_in();
        tick();
        clear_in(); for (int n = 0; n < 32; n++) m_in_r[n] = 1; drive_in();
        tick();
        clear_in(); drive_in();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            for (int k = 0; k < 32; k++) begin
                n_checks++;
                if (yr[k] !== 14'sd0 || yi[k] !== 14'sd0) begin
                    n_fail++;
                    $display("FAIL b2b flushed cyc %0d bin %0d: got R=%0d I=%0d, want R=0 I=0", c, k, yr[k], yi[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        drive_in();
        build_twiddles();
        test_reset();
        test_impulse("impulse", 1, 0);
        test_dc();
        test_mixed();
        test_impulse("neg_impulse", -2, 0);
        test_impulse("imag_impulse", 0, 1);
        test_random_stream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
